// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, state and control-field encodings for the multi-cycle control FSM
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_LW, CLS_SW, CLS_ADDI, CLS_BEQ, CLS_J, CLS_ILLEGAL
  } op_class_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b01;
  localparam logic [1:0] ALUOP_CMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/op_class_decode.sv
// rtl/op_class_decode.sv - combinational opcode to instruction-class decode
module op_class_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output op_class_e  o_op_class
);

  always_comb begin
    o_op_class = CLS_ILLEGAL;
    case (i_opcode)
      OP_RTYPE: o_op_class = CLS_RTYPE;
      OP_LW:    o_op_class = CLS_LW;
      OP_SW:    o_op_class = CLS_SW;
      OP_ADDI:  o_op_class = CLS_ADDI;
      OP_BEQ:   o_op_class = CLS_BEQ;
      OP_J:     o_op_class = CLS_J;
      default:  o_op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle main control FSM for the MIPS-subset datapath
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic [1:0]       pc_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_e           r_state;
  state_e           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  op_class_e        w_class;
  logic             w_retire;
  logic             w_unused_zero;

  // Branch qualification by zero lives in the datapath, not here.
  assign w_unused_zero = zero;

  op_class_decode u_op_class_decode (
    .i_opcode   (opcode),
    .o_op_class (w_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_BOOT;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    aluop         = ALUOP_ADD;
    pc_src        = PCSRC_ALU;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (r_state)
      S_BOOT: w_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (w_class)
          CLS_RTYPE:     w_next = S_EXEC_R;
          CLS_LW, CLS_SW: w_next = S_MEM_ADDR;
          CLS_ADDI:      w_next = S_EXEC_I;
          CLS_BEQ:       w_next = S_BRANCH;
          CLS_J:         w_next = S_JUMP;
          default:       w_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_RTYPE;
        w_next    = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = (w_class == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        w_retire  = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = ALUOP_CMP;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_BOOT;
    endcase
  end

  assign illegal_op = r_illegal;
  assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  typedef struct packed {
    logic [15:0] ctl;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;

  logic mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, reg_write, alu_src_a;
  logic [1:0] alu_src_b, aluop, pc_src;
  logic reg_dst, mem_to_reg, illegal_op;
  logic [31:0] retired;

  logic n_mem_read, n_mem_write, n_iord, n_ir_write, n_pc_write, n_pc_write_cond, n_reg_write, n_alu_src_a;
  logic [1:0] n_alu_src_b, n_aluop, n_pc_src;
  logic n_reg_dst, n_mem_to_reg, n_illegal_op;
  logic [3:0] n_retired;

  logic [15:0] act_ctl, act_ctl4;
  assign act_ctl  = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, reg_write,
                     alu_src_a, alu_src_b, aluop, pc_src, reg_dst, mem_to_reg};
  assign act_ctl4 = {n_mem_read, n_mem_write, n_iord, n_ir_write, n_pc_write, n_pc_write_cond, n_reg_write,
                     n_alu_src_a, n_alu_src_b, n_aluop, n_pc_src, n_reg_dst, n_mem_to_reg};

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .pc_src(pc_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .retired(retired)
  );

  multicycle_control #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .iord(n_iord), .ir_write(n_ir_write),
    .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .reg_write(n_reg_write),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .aluop(n_aluop), .pc_src(n_pc_src),
    .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .illegal_op(n_illegal_op), .retired(n_retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  exp_t q[$];
  exp_t e;
  logic [31:0] m_ret = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Control word per instruction phase, ordered as act_ctl.
  function automatic logic [15:0] mk(input logic rd, wr, io, irw, pcw, pcc, rw, sa,
                                     input logic [1:0] sb, op, ps, input logic rdst, m2r);
    return {rd, wr, io, irw, pcw, pcc, rw, sa, sb, op, ps, rdst, m2r};
  endfunction

  function automatic logic [15:0] cw(input string ph);
    case (ph)
      "FETCH_W":  return mk(1,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
      "FETCH_R":  return mk(1,0,0,1,1,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
      "DECODE":   return mk(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
      "EXEC_R":   return mk(0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b00, 0,0);
      "WB_R":     return mk(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
      "EXEC_I":   return mk(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
      "MEM_ADDR": return mk(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
      "WB_I":     return mk(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0,0);
      "MEM_RD":   return mk(1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
      "MEM_WB":   return mk(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0,1);
      "MEM_WR":   return mk(0,1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
      "BRANCH":   return mk(0,0,0,0,0,1,0,1, 2'b00, 2'b10, 2'b01, 0,0);
      "JUMP":     return mk(0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b10, 0,0);
      default:    return 16'h0000;
    endcase
  endfunction

  task automatic step(input logic rdy, input logic [5:0] op, input string ph, input logic ill);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    opcode    = op;
    zero      = 1'($urandom);
    q.push_back('{ctl: cw(ph), ill: ill, ret: m_ret});
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ctl", {48'd0, act_ctl}, 64'd0);
    chk("reset_ctl_w4", {48'd0, act_ctl4}, 64'd0);
    chk("reset_mem_write", {63'd0, mem_write}, 64'd0);
    chk("reset_illegal", {63'd0, illegal_op}, 64'd0);
    chk("reset_retired", {32'd0, retired}, 64'd0);
    chk("reset_retired_w4", {60'd0, n_retired}, 64'd0);
    m_ret = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = 1'($urandom);
    opcode    = 6'($urandom);
    q.push_back('{ctl: 16'h0000, ill: 1'b0, ret: 32'd0});
  endtask

  task automatic run_instr(input logic [5:0] opc, input int fw, input int mw, input bit abort);
    for (int i = 0; i < fw; i++) step(1'b0, 6'($urandom), "FETCH_W", 1'b0);
    step(1'b1, 6'($urandom), "FETCH_R", 1'b0);
    step(1'($urandom), opc, "DECODE", 1'b0);
    case (opc)
      6'b000000: begin
        step(1'($urandom), opc, "EXEC_R", 1'b0);
        step(1'($urandom), opc, "WB_R", 1'b0);
      end
      6'b001000: begin
        step(1'($urandom), opc, "EXEC_I", 1'b0);
        step(1'($urandom), opc, "WB_I", 1'b0);
      end
      6'b100011: begin
        step(1'($urandom), opc, "MEM_ADDR", 1'b0);
        for (int i = 0; i < mw; i++) step(1'b0, opc, "MEM_RD", 1'b0);
        step(1'b1, opc, "MEM_RD", 1'b0);
        step(1'($urandom), opc, "MEM_WB", 1'b0);
      end
      6'b101011: begin
        step(1'($urandom), opc, "MEM_ADDR", 1'b0);
        for (int i = 0; i < mw; i++) step(1'b0, opc, "MEM_WR", 1'b0);
        if (abort) begin
          do_reset();
          return;
        end
        step(1'b1, opc, "MEM_WR", 1'b0);
      end
      6'b000100: step(1'($urandom), opc, "BRANCH", 1'b0);
      6'b000010: step(1'($urandom), opc, "JUMP", 1'b0);
      default: begin
        for (int i = 0; i < 25; i++) step(1'($urandom), opc, "TRAP", 1'b1);
        return;
      end
    endcase
    m_ret = m_ret + 32'd1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctl", {48'd0, act_ctl}, {48'd0, e.ctl});
        chk("ctl_w4", {48'd0, act_ctl4}, {48'd0, e.ctl});
        chk("illegal_op", {63'd0, illegal_op}, {63'd0, e.ill});
        chk("retired", {32'd0, retired}, {32'd0, e.ret});
        chk("retired_w4", {60'd0, n_retired}, {60'd0, e.ret[3:0]});
      end
    end
  end

  logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010};

  initial begin
    do_reset();
    run_instr(6'b000000, 0, 0, 1'b0);
    run_instr(6'b100011, 0, 2, 1'b0);
    zero = 1'b1;
    run_instr(6'b000100, 0, 0, 1'b0);
    run_instr(6'b000100, 0, 0, 1'b0);
    for (int n = 0; n < 120; n++)
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);

    do_reset();
    for (int n = 0; n < 16; n++) run_instr(6'b000010, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    chk("wrap_retired_w4", {60'd0, n_retired}, 64'd0);
    chk("wrap_retired_32", {32'd0, retired}, 64'd16);

    run_instr(6'b101011, 1, 2, 1'b1);
    run_instr(6'b001000, 1, 0, 1'b0);

    run_instr(6'b111111, 0, 0, 1'b0);
    chk("trap_sticky", {63'd0, illegal_op}, 64'd1);
    do_reset();
    run_instr(6'b000000, 0, 0, 1'b0);

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control FSM for the MIPS-subset processor. It sequences one instruction over several cycles through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath enables, the mux selects and the 2-bit `aluop` consumed by `alucontrol`. It sits beside the datapath, reads the opcode from the instruction register, and handshakes with a single shared instruction/data memory port.

## Interface
- Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.
- Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_read` / `mem_write`  out  1  memory access request, held until `mem_ready`
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ir_write`, `pc_write`, `pc_write_cond`, `reg_write`  out  1  register enables
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- `aluop`  out  2  00 = add, 01 = R-type (decode funct), 10 = compare/branch
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `reg_dst`, `mem_to_reg`  out  1  write-register select / write-data select
- `illegal_op`  out  1  sticky trap flag
- `retired`  out  CNT_W  count of completed instructions

## Operation
- States: BOOT, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, TRAP.
- BOOT: all outputs 0; next state is FETCH.
- FETCH:
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `aluop`=00, `pc_src`=00.
  - `ir_write` and `pc_write` are asserted only in the cycle `mem_ready`=1; the FSM then moves to DECODE, otherwise it stays in FETCH.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `aluop`=00 (branch target into ALUOut). Dispatch on opcode:
  - 000000 → EXEC_R
  - 100011 and 101011 → MEM_ADDR
  - 001000 → EXEC_I
  - 000100 → BRANCH
  - 000010 → JUMP
  - any other opcode → TRAP
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `aluop`=01. Next is WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `aluop`=00. Next is WB_I.
- WB_I: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `aluop`=00. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `iord`=1. Waits for `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1.
- MEM_WR: `mem_write`=1, `iord`=1. Waits for `mem_ready`.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `aluop`=10, `pc_write_cond`=1, `pc_src`=01. The PC updates only if `zero`=1; that qualification happens in the datapath.
- JUMP: `pc_write`=1, `pc_src`=10.
- Last states: WB_R, WB_I, MEM_WB, MEM_WR (on ready), BRANCH and JUMP each return to FETCH and increment `retired` by 1. `retired` wraps modulo 2^CNT_W.
- TRAP:
  - Entry sets `illegal_op`=1.
  - All strobes stay 0 and the FSM remains in TRAP until reset.
  - `retired` is not incremented for the trapping instruction.
- Any output not listed for a state is 0.

## Timing
- Reset (asynchronous assert): state=BOOT, `illegal_op`=0, `retired`=0, every output 0.
- After `rst_n` rises, the first FETCH is at cycle 1 (BOOT occupies cycle 0).
- Strobe types:
  - State-decoded strobes are Moore (combinational from the state register).
  - `ir_write`, FETCH `pc_write` and the MEM_RD/MEM_WR exits are qualified by the same-cycle `mem_ready`.
- Cycles per instruction with `mem_ready` tied high: R 4, addi 4, lw 5, sw 4, beq 3, j 3. Each wait cycle on `mem_ready` adds 1.
- A request stays asserted with stable `iord` until ready; no request is ever withdrawn.
- `mem_ready` is ignored in states that issue no request.
- Reset mid-access drops `mem_read`/`mem_write` immediately (asynchronous).

## Structure
- `ctrl_pkg` holds:
  - opcode constants
  - the state enum
  - `aluop` encodings (ADD=00, RTYPE=01, CMP=10)
  - `alu_src_b` and `pc_src` encodings
- Submodule `op_class_decode`: combinational opcode → class {RTYPE, LW, SW, ADDI, BEQ, J, ILLEGAL}, used for DECODE dispatch.

## Test plan
- R-type (000000), `mem_ready`=1: states FETCH, DECODE, EXEC_R, WB_R; `aluop`=01 in EXEC_R; `reg_write`=1, `reg_dst`=1 in WB_R; `retired` 0→1.
- lw (100011) with `mem_ready` low for 2 cycles in MEM_RD: `mem_read`=1, `iord`=1 held 3 cycles; 7 cycles total; `mem_to_reg`=1 in MEM_WB.
- beq (000100), `zero`=1 then `zero`=0: `pc_write_cond`=1, `aluop`=10, `pc_src`=01 for one cycle; 3 cycles each; `retired` increments both times.
- Opcode 111111: TRAP after DECODE; `illegal_op`=1 and all strobes 0 for 20+ cycles; `retired` unchanged; `rst_n` low clears both.
- `rst_n` pulsed low during MEM_WR wait: `mem_write` drops in the same cycle; the FSM restarts with BOOT, then FETCH.
- `CNT_W`=4, 16 j instructions: `retired` wraps 15→0.
